// File: rtl/module_disp_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller.
// Scans hex digits onto a shared segment bus with a blank interval at the start
// of every digit slot, optional leading-zero suppression, and a double-buffered
// display register that only changes on the frame wrap so a frame never tears.
`timescale 1ns/1ps

module module_disp_scan_ctrl #(
   parameter int N_DIGITS         = 4,
   parameter int TICK_DIV         = 27000,
   parameter int BLANK_CYC        = 16,
   parameter int ANODE_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_en,
   input  logic                          i_load,
   input  logic [4*N_DIGITS-1:0]         i_digits,
   input  logic [N_DIGITS-1:0]           i_dp,
   input  logic                          i_blank_lz,
   output logic                          o_pending,
   output logic [N_DIGITS-1:0]           o_an,
   output logic [6:0]                    o_seg,
   output logic                          o_dp,
   output logic [$clog2(N_DIGITS)-1:0]   o_digit_idx,
   output logic                          o_frame_tick
);

   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int CNT_W = $clog2(TICK_DIV);

   localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_ONE        = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(N_DIGITS - 1);

   // Inactive levels; an active level is obtained by XOR with the active-high pattern.
   localparam logic [N_DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
   localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t                  r_state, w_state_next;
   logic [CNT_W-1:0]        r_cnt, w_cnt_next;
   logic [IDX_W-1:0]        r_idx, w_idx_next;

   logic [4*N_DIGITS-1:0]   r_disp_dig, r_pend_dig;
   logic [N_DIGITS-1:0]     r_disp_dp, r_pend_dp;
   logic                    r_pending;
   logic                    r_frame_tick;

   logic [N_DIGITS-1:0]     r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;

   logic [N_DIGITS-1:1]     w_empty;
   logic [N_DIGITS-1:0]     w_blank;
   logic                    w_above;
   logic                    w_wrap;
   logic                    w_lit;
   logic [3:0]              w_nib;
   logic [N_DIGITS-1:0]     w_an_hot;
   logic [N_DIGITS-1:0]     w_an_next;
   logic [6:0]              w_seg_next;
   logic                    w_dp_next;

   // Hex nibble to active-high {g,f,e,d,c,b,a}.
   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   // A digit is a suppression candidate when it shows zero with no decimal point.
   for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_empty
      assign w_empty[gi] = (r_disp_dig[4*gi +: 4] == 4'h0) && !r_disp_dp[gi];
   end

   // Leading-zero mask: walk down from the top digit while every digit so far is blanked.
   always_comb begin
      w_blank = '0;
      w_above = i_blank_lz;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         if (w_above && w_empty[k]) begin
            w_blank[k] = 1'b1;
         end else begin
            w_above = 1'b0;
         end
      end
   end

   // Last DRIVE cycle of the top digit: the next edge starts a new frame.
   assign w_wrap = (r_state == ST_DRIVE) && i_en && (r_cnt == CNT_SLOT_LAST) && (r_idx == IDX_LAST);

   // Next-state, slot counter and digit index.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      if (!i_en) begin
         w_state_next = ST_IDLE;
         w_cnt_next   = '0;
         w_idx_next   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_next = ST_BLANK;
               w_cnt_next   = '0;
               w_idx_next   = '0;
            end
            ST_BLANK: begin
               w_cnt_next = r_cnt + CNT_ONE;
               if (r_cnt == CNT_BLANK_LAST) begin
                  w_state_next = ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (r_cnt == CNT_SLOT_LAST) begin
                  w_state_next = ST_BLANK;
                  w_cnt_next   = '0;
                  w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_ONE;
               end else begin
                  w_cnt_next = r_cnt + CNT_ONE;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
               w_idx_next   = '0;
            end
         endcase
      end
   end

   // Pin values for the upcoming cycle, derived from the next state so they can be registered.
   // The display register is stable whenever DRIVE is entered (it only changes on edges into BLANK).
   always_comb begin
      w_an_hot             = '0;
      w_an_hot[w_idx_next] = 1'b1;
      w_nib                = r_disp_dig[{w_idx_next, 2'b00} +: 4];
      w_lit                = (w_state_next == ST_DRIVE) && !w_blank[w_idx_next];
      w_an_next            = AN_OFF;
      w_seg_next           = SEG_OFF;
      w_dp_next            = DP_OFF;
      if (w_lit) begin
         w_an_next  = AN_OFF ^ w_an_hot;
         w_seg_next = SEG_OFF ^ f_decode(w_nib);
         w_dp_next  = DP_OFF ^ r_disp_dp[w_idx_next];
      end
   end

   // Scan state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
      end
   end

   // Double buffer: loads land in the pending buffer, move to the display on wrap (or at once when idle).
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_disp_dig   <= '0;
         r_disp_dp    <= '0;
         r_pend_dig   <= '0;
         r_pend_dp    <= '0;
         r_pending    <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_wrap;
         if (w_wrap) begin
            // A load arriving on the wrap cycle bypasses the buffer so it is not held a whole frame.
            if (i_load) begin
               r_disp_dig <= i_digits;
               r_disp_dp  <= i_dp;
            end else if (r_pending) begin
               r_disp_dig <= r_pend_dig;
               r_disp_dp  <= r_pend_dp;
            end
            r_pending <= 1'b0;
         end else begin
            if ((r_state == ST_IDLE) && r_pending) begin
               r_disp_dig <= r_pend_dig;
               r_disp_dp  <= r_pend_dp;
            end
            if (i_load) begin
               r_pend_dig <= i_digits;
               r_pend_dp  <= i_dp;
               r_pending  <= 1'b1;
            end else if (r_state == ST_IDLE) begin
               r_pending <= 1'b0;
            end
         end
      end
   end

   // Registered anode and segment pins.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_an  <= AN_OFF;
         r_seg <= SEG_OFF;
         r_dp  <= DP_OFF;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
         r_dp  <= w_dp_next;
      end
   end

   assign o_pending    = r_pending;
   assign o_an         = r_an;
   assign o_seg        = r_seg;
   assign o_dp         = r_dp;
   assign o_digit_idx  = r_idx;
   assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_module_disp_scan_ctrl.sv
// Self-checking bench for module_disp_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles,
// active-low anodes and segments). Expected pin values come from a table of digit patterns
// and a frame-position formula; they are queued when stimulus is driven and checked at negedge.
`timescale 1ns/1ps

module tb_module_disp_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        pending;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_out;
   logic [1:0]  idx;
   logic        tick;

   always #5 clk = ~clk;

   module_disp_scan_ctrl #(
      .N_DIGITS         (4),
      .TICK_DIV         (8),
      .BLANK_CYC        (2),
      .ANODE_ACTIVE_LOW (1),
      .SEG_ACTIVE_LOW   (1)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_en         (en),
      .i_load       (load),
      .i_digits     (digits),
      .i_dp         (dp_in),
      .i_blank_lz   (blank_lz),
      .o_pending    (pending),
      .o_an         (an),
      .o_seg        (seg),
      .o_dp         (dp_out),
      .o_digit_idx  (idx),
      .o_frame_tick (tick)
   );

   typedef struct packed {
      logic        rst_n;
      logic        en;
      logic        load;
      logic [15:0] dig;
      logic [3:0]  dp;
      logic        lz;
   } in_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [1:0] idx;
      logic       tick;
      logic       pend;
   } out_t;

   typedef struct {
      out_t o;
      int   due;
      int   ph;
      int   t;
   } exp_t;

   // One display pattern: inputs plus the active-low segment code and lit flag per digit.
   typedef struct packed {
      logic [15:0]     dig;
      logic [3:0]      dp;
      logic            lz;
      logic [3:0][6:0] seg;
      logic [3:0]      lit;
   } row_t;

   localparam int N_ROWS = 10;

   row_t rows [N_ROWS];
   exp_t q [$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   ph       = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare every expectation whose cycle has arrived.
   always @(negedge clk) begin
      exp_t e;
      out_t act;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e   = q.pop_front();
         act = {an, seg, dp_out, idx, tick, pending};
         n_checks++;
         if (act !== e.o) begin
            n_errors++;
            $display("FAIL pins ph=%0d t=%0d got an=%b seg=%h dp=%b idx=%0d tick=%b pend=%b want an=%b seg=%h dp=%b idx=%0d tick=%b pend=%b",
                     e.ph, e.t, act.an, act.seg, act.dp, act.idx, act.tick, act.pend,
                     e.o.an, e.o.seg, e.o.dp, e.o.idx, e.o.tick, e.o.pend);
         end
      end
   end

   function automatic in_t mk_in(logic r, logic e, logic l, logic [15:0] d, logic [3:0] p, logic z);
      return {r, e, l, d, p, z};
   endfunction

   function automatic row_t mk_row(logic [15:0] d, logic [3:0] p, logic z,
                                   logic [6:0] s3, logic [6:0] s2, logic [6:0] s1, logic [6:0] s0,
                                   logic [3:0] lit);
      return {d, p, z, s3, s2, s1, s0, lit};
   endfunction

   function automatic out_t idle_out(logic pend);
      return {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0, pend};
   endfunction

   // Expected pins at frame position t (t=0 is the first BLANK cycle after enable).
   function automatic out_t scan_out(int t, row_t r, logic pend);
      out_t o;
      int   slot;
      int   off;
      logic lit;
      slot   = (t / 8) % 4;
      off    = t % 8;
      lit    = (off >= 2) && r.lit[slot];
      o.an   = lit ? ~(4'b0001 << slot) : 4'hF;
      o.seg  = lit ? r.seg[slot] : 7'h7F;
      o.dp   = lit ? ~r.dp[slot] : 1'b1;
      o.idx  = 2'(slot);
      o.tick = (t > 0) && (t % 32 == 0);
      o.pend = pend;
      return o;
   endfunction

   // Drive inputs just after a rising edge and queue what the pins must show after the next one.
   task automatic step(input in_t i, input out_t o, input int t);
      exp_t e;
      @(posedge clk);
      #2;
      rst_n    = i.rst_n;
      en       = i.en;
      load     = i.load;
      digits   = i.dig;
      dp_in    = i.dp;
      blank_lz = i.lz;
      e.o   = o;
      e.due = cyc + 1;
      e.ph  = ph;
      e.t   = t;
      q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t cur;
      logic ld;
      logic [15:0] ld_dig;

      rst_n = 1'b0; en = 1'b1; load = 1'b0; digits = '0; dp_in = '0; blank_lz = 1'b0;

      rows[0] = mk_row(16'h1234, 4'b0000, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19, 4'b1111);
      rows[1] = mk_row(16'h0070, 4'b0000, 1'b1, 7'h7F, 7'h7F, 7'h78, 7'h40, 4'b0011);
      rows[2] = mk_row(16'h0000, 4'b0000, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b0001);
      rows[3] = mk_row(16'h0000, 4'b1000, 1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
      rows[4] = mk_row(16'hABCD, 4'b0000, 1'b0, 7'h08, 7'h03, 7'h46, 7'h21, 4'b1111);
      rows[5] = mk_row(16'h0000, 4'b0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
      rows[6] = mk_row(16'h0105, 4'b0000, 1'b1, 7'h7F, 7'h79, 7'h40, 7'h12, 4'b0111);
      rows[7] = mk_row(16'hE9F6, 4'b0101, 1'b1, 7'h06, 7'h10, 7'h0E, 7'h02, 4'b1111);
      rows[8] = mk_row(16'h0008, 4'b0100, 1'b1, 7'h7F, 7'h40, 7'h40, 7'h00, 4'b0111);
      rows[9] = mk_row(16'h0070, 4'b0000, 1'b0, 7'h40, 7'h40, 7'h78, 7'h40, 4'b1111);

      // Reset held with enable high.
      ph = 0;
      for (int k = 0; k < 3; k++) step(mk_in(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0), idle_out(1'b0), k);
      $display("reset: 3 cycles with en=1");

      // Table: load while idle, transfer, scan one full frame plus the wrap, disable.
      ph = 1;
      for (int r = 0; r < N_ROWS; r++) begin
         cur = rows[r];
         step(mk_in(1'b1, 1'b0, 1'b1, cur.dig, cur.dp, cur.lz), idle_out(1'b1), 0);
         step(mk_in(1'b1, 1'b0, 1'b0, cur.dig, cur.dp, cur.lz), idle_out(1'b0), 0);
         for (int t = 0; t <= 32; t++) step(mk_in(1'b1, 1'b1, 1'b0, cur.dig, cur.dp, cur.lz), scan_out(t, cur, 1'b0), t);
         step(mk_in(1'b1, 1'b0, 1'b0, cur.dig, cur.dp, cur.lz), idle_out(1'b0), 0);
         $display("row %0d: digits=%h dp=%b lz=%b scanned", r, cur.dig, cur.dp, cur.lz);
      end

      // Tear-free: load during digit-1 slot, then a load exactly on the wrap cycle.
      ph = 2;
      step(mk_in(1'b1, 1'b0, 1'b1, rows[0].dig, 4'h0, 1'b0), idle_out(1'b1), 0);
      step(mk_in(1'b1, 1'b0, 1'b0, rows[0].dig, 4'h0, 1'b0), idle_out(1'b0), 0);
      for (int t = 0; t < 96; t++) begin
         cur    = (t < 32) ? rows[0] : ((t < 64) ? rows[4] : rows[0]);
         ld     = (t == 10) || (t == 64);
         ld_dig = (t == 10) ? rows[4].dig : rows[0].dig;
         step(mk_in(1'b1, 1'b1, ld, ld_dig, 4'h0, 1'b0), scan_out(t, cur, (t >= 10) && (t < 32)), t);
      end
      $display("tear-free: mid-frame load held to wrap, wrap-cycle load shown next frame");

      // Enable dropped in digit-2 DRIVE, then re-asserted.
      ph = 3;
      step(mk_in(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0), idle_out(1'b0), 0);
      for (int t = 0; t <= 20; t++) step(mk_in(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0), scan_out(t, rows[0], 1'b0), t);
      step(mk_in(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0), idle_out(1'b0), 21);
      for (int t = 0; t <= 12; t++) step(mk_in(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0), scan_out(t, rows[0], 1'b0), t);
      $display("enable: drop in digit 2 then restart from digit 0");

      // Reset mid-frame with a pending load: both the pending and displayed data are discarded.
      ph = 4;
      step(mk_in(1'b1, 1'b1, 1'b1, rows[4].dig, 4'h0, 1'b0), scan_out(13, rows[0], 1'b1), 13);
      step(mk_in(1'b1, 1'b1, 1'b0, rows[4].dig, 4'h0, 1'b0), scan_out(14, rows[0], 1'b1), 14);
      step(mk_in(1'b0, 1'b1, 1'b0, rows[4].dig, 4'h0, 1'b0), idle_out(1'b0), 0);
      step(mk_in(1'b0, 1'b1, 1'b0, rows[4].dig, 4'h0, 1'b0), idle_out(1'b0), 1);
      step(mk_in(1'b1, 1'b0, 1'b0, rows[4].dig, 4'h0, 1'b0), idle_out(1'b0), 2);
      for (int t = 0; t <= 32; t++) step(mk_in(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0), scan_out(t, rows[5], 1'b0), t);
      $display("reset mid-frame: pending load dropped, display cleared");

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
